// File: rtl/scan_decoder_if.sv
// Control and decoded-output bundle for scan_decoder.
// master drives the controls; slave is the decoder.
interface scan_decoder_if #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 16
);
  localparam int unsigned OUT_W = 1 << SEL_W;

  logic               enable;
  logic               mode;
  logic [SEL_W-1:0]   din;
  logic [SEL_W-1:0]   last;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   dout;
  logic [SEL_W-1:0]   idx;
  logic               wrap;

  modport master (
    output enable, mode, din, last, dwell,
    input  dout, idx, wrap
  );

  modport slave (
    input  enable, mode, din, last, dwell,
    output dout, idx, wrap
  );
endinterface

// File: rtl/scan_decoder.sv
// One-cold decoder with direct select and timed auto-scan modes.
// Define SCAN_DECODER_BLANK_EN to insert a one-cycle all-off gap at every scan advance.
module scan_decoder #(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  scan_decoder_if.slave bus
);

  localparam int unsigned OUT_W = 1 << SEL_W;

`ifdef SCAN_DECODER_BLANK_EN
  typedef enum logic [1:0] {StOff, StDirect, StScan, StBlank} state_e;
`else
  typedef enum logic [1:0] {StOff, StDirect, StScan} state_e;
`endif

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]   dout_q, dout_d;
  logic               wrap_q, wrap_d;
  logic [SEL_W-1:0]   adv_idx;
  logic               adv_wrap;

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] sel);
    logic [OUT_W-1:0] one;
    one = OUT_W'(1);
    return ~(one << sel);
  endfunction

  // last is compared live, so lowering it below idx wraps on the next advance
  always_comb begin
    adv_idx  = idx_q + SEL_W'(1);
    adv_wrap = 1'b0;
    if (idx_q >= bus.last) begin
      adv_idx  = '0;
      adv_wrap = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    wrap_d  = 1'b0;
    if (bus.enable) begin
      state_d = StOff;
      idx_d   = '0;
      cnt_d   = '0;
      dout_d  = '1;
    end else if (!bus.mode) begin
      state_d = StDirect;
      idx_d   = bus.din;
      cnt_d   = '0;
      dout_d  = decode(bus.din);
    end else begin
      unique case (state_q)
        StScan: begin
          if (cnt_q == bus.dwell) begin
            cnt_d  = '0;
            idx_d  = adv_idx;
            wrap_d = adv_wrap;
`ifdef SCAN_DECODER_BLANK_EN
            state_d = StBlank;
            dout_d  = '1;
`else
            dout_d  = decode(adv_idx);
`endif
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end
`ifdef SCAN_DECODER_BLANK_EN
        StBlank: begin
          state_d = StScan;
          cnt_d   = '0;
          dout_d  = decode(idx_q);
        end
`endif
        default: begin
          // OFF or DIRECT entering scan always restarts from index 0
          state_d = StScan;
          idx_d   = '0;
          cnt_d   = '0;
          dout_d  = decode('0);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOff;
      idx_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '1;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: a reference model or closed-form sequence
// pushes expected outputs each cycle; they are popped and compared after the edge.
module tb_scan_decoder;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned DWELL_W = 16;

  typedef struct packed {
    logic [7:0] dout;
    logic [2:0] idx;
    logic       wrap;
  } obs_t;

  typedef enum int {MOff, MDirect, MScan, MBlank} mst_t;

  logic clk;
  logic rst_n;

  scan_decoder_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

  scan_decoder #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  obs_t sb[$];
  obs_t got, exp_v, mdl;

  mst_t        m_st;
  logic [2:0]  m_idx;
  logic [15:0] m_cnt;
  logic        m_wrap;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.dout = bus.dout;
    o.idx  = bus.idx;
    o.wrap = bus.wrap;
    return o;
  endfunction

  task automatic drive(input logic en, input logic md, input logic [2:0] d,
                       input logic [2:0] l, input logic [15:0] dw);
    bus.enable = en;
    bus.mode   = md;
    bus.din    = d;
    bus.last   = l;
    bus.dwell  = dw;
  endtask

  task automatic model_reset();
    m_st   = MOff;
    m_idx  = '0;
    m_cnt  = '0;
    m_wrap = 1'b0;
    sb.delete();
  endtask

  // Advances the reference model by one clock edge using the current inputs.
  task automatic predict(output obs_t e);
    m_wrap = 1'b0;
    if (bus.enable) begin
      m_st = MOff; m_idx = '0; m_cnt = '0;
    end else if (!bus.mode) begin
      m_st = MDirect; m_idx = bus.din; m_cnt = '0;
    end else if (m_st == MOff || m_st == MDirect) begin
      m_st = MScan; m_idx = '0; m_cnt = '0;
    end else if (m_st == MBlank) begin
      m_st = MScan; m_cnt = '0;
    end else if (m_cnt == bus.dwell) begin
      m_cnt = '0;
      if (m_idx >= bus.last) begin
        m_idx = '0; m_wrap = 1'b1;
      end else begin
        m_idx = m_idx + 3'd1;
      end
`ifdef SCAN_DECODER_BLANK_EN
      m_st = MBlank;
`endif
    end else begin
      m_cnt = m_cnt + 16'd1;
    end
    e.dout = (m_st == MOff || m_st == MBlank) ? 8'hFF : ~(8'h01 << m_idx);
    e.idx  = m_idx;
    e.wrap = m_wrap;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 3'd0, 3'd7, 16'd0);
    model_reset();
    #12;
    got = observe(); checks++;
    if (got !== obs_t'({8'hFF, 3'd0, 1'b0})) begin
      errors++;
      $display("FAIL reset_hold: got dout=%h idx=%0d wrap=%b, want dout=ff idx=0 wrap=0",
               got.dout, got.idx, got.wrap);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      predict(mdl); sb.push_back(mdl);
      @(posedge clk); #1;
      got = observe(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL reset_off c%0d: got %h/%0d/%b want %h/%0d/%b", i,
                 got.dout, got.idx, got.wrap, exp_v.dout, exp_v.idx, exp_v.wrap);
      end
    end
  endtask

  task automatic test_direct();
    logic [2:0] pat [10] = '{3'd5, 3'd0, 3'd7, 3'd1, 3'd6, 3'd2, 3'd5, 3'd3, 3'd4, 3'd0};
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, pat[i], 3'd7, 16'd0);
      predict(mdl); sb.push_back(mdl);
      @(posedge clk); #1;
      got = observe(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL direct din=%0d: got %h/%0d/%b want %h/%0d/%b", pat[i],
                 got.dout, got.idx, got.wrap, exp_v.dout, exp_v.idx, exp_v.wrap);
      end
      if (i == 0) begin
        checks++;
        if (got.dout !== 8'b1101_1111 || got.idx !== 3'd5) begin
          errors++;
          $display("FAIL direct_first: got dout=%h idx=%0d want dout=df idx=5",
                   got.dout, got.idx);
        end
      end
    end
  endtask

  task automatic test_scan_wrap();
    // Closed-form expectation: idx = (k/3) mod 8, wrap on each return to 0.
    for (int k = 0; k < 30; k++) begin
      drive(1'b0, 1'b1, 3'd0, 3'd7, 16'd2);
      predict(mdl);
`ifdef SCAN_DECODER_BLANK_EN
      sb.push_back(mdl);
`else
      exp_v.idx  = 3'((k / 3) % 8);
      exp_v.dout = ~(8'h01 << exp_v.idx);
      exp_v.wrap = (k > 0) && (k % 24 == 0);
      sb.push_back(exp_v);
`endif
      @(posedge clk); #1;
      got = observe(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL scan_wrap k=%0d: got %h/%0d/%b want %h/%0d/%b", k,
                 got.dout, got.idx, got.wrap, exp_v.dout, exp_v.idx, exp_v.wrap);
      end
    end
  endtask

  task automatic test_last_change();
    logic [2:0] prev;
    int         seen = 0;
    for (int i = 0; i < 60; i++) begin
      drive(1'b0, 1'b1, 3'd0, (m_idx == 3'd6 || seen > 0) ? 3'd3 : 3'd7, 16'd2);
      if (m_idx == 3'd6) seen = 1;
      prev = bus.idx;
      predict(mdl); sb.push_back(mdl);
      @(posedge clk); #1;
      got = observe(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL last_change i=%0d: got %h/%0d/%b want %h/%0d/%b", i,
                 got.dout, got.idx, got.wrap, exp_v.dout, exp_v.idx, exp_v.wrap);
      end
      if (seen == 1 && prev == 3'd6 && got.idx != 3'd6) begin
        seen = 2; checks++;
        if (got.idx !== 3'd0 || got.wrap !== 1'b1) begin
          errors++;
          $display("FAIL last_lowered: got idx=%0d wrap=%b want idx=0 wrap=1",
                   got.idx, got.wrap);
        end
      end
    end
    checks++;
    if (seen != 2) begin
      errors++;
      $display("FAIL last_lowered_reached: got stage=%0d want 2", seen);
    end
  endtask

  task automatic test_corner_dwell_last();
    int wraps = 0;
    for (int i = 0; i < 40; i++) begin
      if (i < 20) drive(1'b0, 1'b1, 3'd0, 3'd0, 16'd3);
      else        drive(1'b0, 1'b1, 3'd0, 3'd7, 16'd0);
      predict(mdl); sb.push_back(mdl);
      @(posedge clk); #1;
      got = observe(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL corner i=%0d: got %h/%0d/%b want %h/%0d/%b", i,
                 got.dout, got.idx, got.wrap, exp_v.dout, exp_v.idx, exp_v.wrap);
      end
      if (i >= 4 && i < 20) wraps += int'(got.wrap);
    end
    checks++;
    if (wraps != 4) begin
      errors++;
      $display("FAIL last0_wrap_count: got %0d want 4", wraps);
    end
  endtask

  task automatic test_enable();
    for (int i = 0; i < 16; i++) begin
      drive((i == 9) ? 1'b1 : 1'b0, 1'b1, 3'd0, 3'd7, 16'd1);
      predict(mdl); sb.push_back(mdl);
      @(posedge clk); #1;
      got = observe(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL enable i=%0d: got %h/%0d/%b want %h/%0d/%b", i,
                 got.dout, got.idx, got.wrap, exp_v.dout, exp_v.idx, exp_v.wrap);
      end
      if (i == 9 || i == 10) begin
        checks++;
        if (got.dout !== ((i == 9) ? 8'hFF : 8'hFE) || got.idx !== 3'd0) begin
          errors++;
          $display("FAIL enable_edge i=%0d: got dout=%h idx=%0d", i, got.dout, got.idx);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int hit = 0;
    for (int i = 0; i < 60; i++) begin
      drive(1'b0, 1'b1, 3'd0, 3'd7, 16'd1);
      predict(mdl); sb.push_back(mdl);
      @(posedge clk); #1;
      got = observe(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL async i=%0d: got %h/%0d/%b want %h/%0d/%b", i,
                 got.dout, got.idx, got.wrap, exp_v.dout, exp_v.idx, exp_v.wrap);
      end
      if (hit == 0 && m_idx == 3'd4) begin
        hit = 1;
        #3 rst_n = 1'b0;
        #1;
        got = observe(); checks++;
        if (got !== obs_t'({8'hFF, 3'd0, 1'b0})) begin
          errors++;
          $display("FAIL async_immediate: got dout=%h idx=%0d wrap=%b want ff/0/0",
                   got.dout, got.idx, got.wrap);
        end
        model_reset();
        #2 rst_n = 1'b1;
      end
    end
    checks++;
    if (hit != 1) begin
      errors++;
      $display("FAIL async_reached: got %0d want 1", hit);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) != 0),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            16'($urandom_range(0, 3)));
      predict(mdl); sb.push_back(mdl);
      @(posedge clk); #1;
      got = observe(); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL random i=%0d: got %h/%0d/%b want %h/%0d/%b", i,
                 got.dout, got.idx, got.wrap, exp_v.dout, exp_v.idx, exp_v.wrap);
      end
    end
  endtask

`ifdef SCAN_DECODER_BLANK_EN
  task automatic test_blank();
    logic [7:0] seq_d [5] = '{8'hFE, 8'hFF, 8'hFD, 8'hFF, 8'hFE};
    logic       seq_w [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    drive(1'b1, 1'b1, 3'd0, 3'd1, 16'd0);
    predict(mdl);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 3'd0, 3'd1, 16'd0);
      predict(mdl);
      sb.push_back(obs_t'({seq_d[i], mdl.idx, seq_w[i]}));
      @(posedge clk); #1;
      got = observe(); exp_v = sb.pop_front(); checks++;
      if (got.dout !== exp_v.dout || got.wrap !== exp_v.wrap || got !== mdl) begin
        errors++;
        $display("FAIL blank i=%0d: got dout=%h wrap=%b want dout=%h wrap=%b", i,
                 got.dout, got.wrap, exp_v.dout, exp_v.wrap);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_direct();
    test_scan_wrap();
    test_last_change();
    test_corner_dwell_last();
    test_enable();
    test_async_reset();
    test_back_to_back();
`ifdef SCAN_DECODER_BLANK_EN
    test_blank();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
